// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, word-count helper and round-constant table.
// Pure declarations; no logic, no latency.
// Used by key_expansion and available to the cipher datapath.
package aes_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } kexp_state_t;

  // Total 32-bit words in the schedule for a given round count.
  function automatic int word_count(input int nr);
    return 4 * (nr + 1);
  endfunction

  // Round constant Rcon[n] (high byte of the word), n = 1..10.
  function automatic logic [7:0] rcon(input int n);
    logic [7:0] rc;
    case (n)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Bus between a key-schedule requester and key_expansion.
// Latency/backpressure are defined by the slave: start is only sampled while idle.
// master drives start/key_in, slave returns busy/done and the full schedule.
interface key_expansion_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic                   start;
  logic [Nk*32-1:0]       key_in;
  logic                   busy;
  logic                   done;
  logic [(Nr+1)*128-1:0]  w;

  modport master (output start, key_in, input busy, done, w);
  modport slave  (input start, key_in, output busy, done, w);
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out.
// Purely combinational, zero latency.
// No flow control; shared by key expansion and the cipher rounds.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Row-major table, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  // Bit position of the selected entry's MSB.
  always_comb begin
    idx   = 11'd2047 - {in_i, 3'b000};
    out_o = SBOX_TBL[idx -: 8];
  end

endmodule

// File: rtl/key_expansion.sv
// AES key schedule: expands an Nk-word key into 4*(Nr+1) words, one word per clock.
// Latency: 4*(Nr+1)-Nk EXPAND cycles after the start edge; done pulses the cycle after.
// start is ignored while busy; KEYEXP_ZEROIZE_EN clears stale schedule words on start.
module key_expansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic          clk,
  input  logic          rst,
  key_expansion_if.slave kif
);

  localparam int NW = word_count(Nr);
  localparam int IW = $clog2(NW);

  kexp_state_t   state_q;
  logic [IW-1:0] i_q;
  logic          done_q;
  logic [31:0]   w_q [NW];

  logic [31:0] prev_w, old_w, rot_w, sub_in, sub_out, temp_w, new_w;
  int          i_mod;

  // Next schedule word from w[i-1] and w[i-Nk].
  always_comb begin
    prev_w = w_q[i_q - IW'(1)];
    old_w  = w_q[i_q - IW'(Nk)];
    i_mod  = int'(i_q) % Nk;
    rot_w  = {prev_w[23:0], prev_w[31:24]};
    sub_in = (i_mod == 0) ? rot_w : prev_w;
    temp_w = prev_w;
    if (i_mod == 0) begin
      temp_w = sub_out ^ {rcon(int'(i_q) / Nk), 24'h0};
    end else if (Nk == 8 && i_mod == 4) begin
      temp_w = sub_out;
    end
    new_w = old_w ^ temp_w;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (sub_in[8*b +: 8]),
      .out_o (sub_out[8*b +: 8])
    );
  end

  // Control FSM plus schedule storage: load on start, one word per EXPAND cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (kif.start) begin
            for (int k = 0; k < Nk; k++) w_q[k] <= kif.key_in[Nk*32-1-32*k -: 32];
`ifdef KEYEXP_ZEROIZE_EN
            for (int k = Nk; k < NW; k++) w_q[k] <= '0;
`endif
            i_q     <= IW'(Nk);
            state_q <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          w_q[i_q] <= new_w;
          i_q      <= i_q + IW'(1);
          if (i_q == IW'(NW - 1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign kif.busy = (state_q == ST_EXPAND);
  assign kif.done = done_q;

  for (genvar j = 0; j < NW; j++) begin : g_wout
    assign kif.w[NW*32-1-32*j -: 32] = w_q[j];
  end

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion at Nk = 4, 6 and 8 against a FIPS-197 style model.
// The model derives the S-box from GF(2^8) inversion and Rcon by repeated doubling.
// Prints one summary line; FAIL lines for any mismatch.
module tb_key_expansion;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  key_expansion_if #(.Nk(4), .Nr(10)) if4 ();
  key_expansion_if #(.Nk(6), .Nr(12)) if6 ();
  key_expansion_if #(.Nk(8), .Nr(14)) if8 ();

  key_expansion #(.Nk(4), .Nr(10)) u_dut4 (.clk(clk), .rst(rst), .kif(if4));
  key_expansion #(.Nk(6), .Nr(12)) u_dut6 (.clk(clk), .rst(rst), .kif(if6));
  key_expansion #(.Nk(8), .Nr(14)) u_dut8 (.clk(clk), .rst(rst), .kif(if8));

  always #5 clk = ~clk;

  logic [7:0] sb [256];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotb(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotb(inv, 1) ^ rotb(inv, 2) ^ rotb(inv, 3) ^ rotb(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Schedule packed with word j at [1919-32*j -: 32]; key right-aligned in 256 bits.
  function automatic logic [1919:0] ref_sched(input int nk, input logic [255:0] key);
    logic [31:0]   wd [60];
    logic [1919:0] r = '0;
    logic [7:0]    rc = 8'h01;
    logic [31:0]   t;
    int            nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) wd[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int j = 0; j < nw; j++) r[1919-32*j -: 32] = wd[j];
    return r;
  endfunction

  // ---------------- DUT access ----------------
  task automatic set_in(input int nk, input logic s, input logic [255:0] k);
    case (nk)
      4:       begin if4.start = s; if4.key_in = k[127:0]; end
      6:       begin if6.start = s; if6.key_in = k[191:0]; end
      default: begin if8.start = s; if8.key_in = k[255:0]; end
    endcase
  endtask

  function automatic logic get_busy(input int nk);
    return (nk == 4) ? if4.busy : (nk == 6) ? if6.busy : if8.busy;
  endfunction

  function automatic logic get_done(input int nk);
    return (nk == 4) ? if4.done : (nk == 6) ? if6.done : if8.done;
  endfunction

  function automatic logic get_wnz(input int nk);
    return (nk == 4) ? |if4.w : (nk == 6) ? |if6.w : |if8.w;
  endfunction

  function automatic logic [31:0] get_word(input int nk, input int j);
    case (nk)
      4:       return if4.w[1407-32*j -: 32];
      6:       return if6.w[1663-32*j -: 32];
      default: return if8.w[1919-32*j -: 32];
    endcase
  endfunction

  function automatic logic [255:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present start for one edge, then scramble key_in (must have no effect).
  task automatic start_dut(input int nk, input logic [255:0] key);
    set_in(nk, 1'b1, key);
    @(posedge clk); #1;
    set_in(nk, 1'b0, rnd_key());
  endtask

  task automatic wait_done(input int nk, output int n);
    n = 0;
    while (!get_done(nk) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_seen", get_done(nk), 1'b1);
  endtask

  task automatic check_sched(input string tag, input int nk, input logic [255:0] key);
    logic [1919:0] e = ref_sched(nk, key);
    int bad = 0;
    for (int j = 0; j < 4 * (nk + 7); j++)
      if (get_word(nk, j) !== e[1919-32*j -: 32]) bad++;
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  // Full expansion: latency, schedule, single-cycle done, idle afterwards.
  task automatic run_one(input int nk, input logic [255:0] key);
    int n;
    start_dut(nk, key);
    wait_done(nk, n);
    check_eq("latency", 64'(n + 1), 64'(4 * (nk + 7) - nk + 1));
    check_sched("sched", nk, key);
    @(posedge clk); #1;
    check_eq("done_pulse", get_done(nk), 1'b0);
    check_eq("idle_busy", get_busy(nk), 1'b0);
  endtask

  localparam logic [255:0] KEY4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY8 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0]  ka, kb, kc;
    logic [1919:0] prev;
    int            n;
    n_chk  = 0;
    n_pass = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    set_in(4, 1'b0, '0);
    set_in(6, 1'b0, '0);
    set_in(8, 1'b0, '0);
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    for (int nk = 4; nk <= 8; nk += 2) begin
      check_eq("rst_busy", get_busy(nk), 1'b0);
      check_eq("rst_done", get_done(nk), 1'b0);
      check_eq("rst_w", get_wnz(nk), 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Published key vectors.
    run_one(4, KEY4);
    check_eq("k4_w4", get_word(4, 4), 32'ha0fafe17);
    check_eq("k4_w43", get_word(4, 43), 32'hb6630ca6);
    run_one(6, KEY6);
    check_eq("k6_w6", get_word(6, 6), 32'hfe0c91f7);
    check_eq("k6_w51", get_word(6, 51), 32'h01002202);
    run_one(8, KEY8);
    check_eq("k8_w8", get_word(8, 8), 32'h9ba35411);
    check_eq("k8_w59", get_word(8, 59), 32'h706c631e);

    // Random keys at every size.
    for (int r = 0; r < 3; r++)
      for (int nk = 4; nk <= 8; nk += 2) run_one(nk, rnd_key());

    // Schedule holds in idle whatever key_in does.
    ka = rnd_key();
    run_one(8, ka);
    set_in(8, 1'b0, rnd_key());
    repeat (5) @(posedge clk);
    #1;
    check_sched("idle_hold", 8, ka);

    // start re-pulsed with another key during EXPAND cycle 10 is ignored.
    ka = rnd_key();
    kb = rnd_key();
    start_dut(4, ka);
    repeat (9) @(posedge clk);
    #1;
    set_in(4, 1'b1, kb);
    @(posedge clk); #1;
    set_in(4, 1'b0, kb);
    check_eq("busy_mid", get_busy(4), 1'b1);
    wait_done(4, n);
    check_eq("repulse_lat", 64'(11 + n), 64'd41);
    check_sched("repulse_sched", 4, ka);

    // Asynchronous reset at EXPAND cycle 20, then a clean restart.
    start_dut(4, kb);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mrst_busy", get_busy(4), 1'b0);
    check_eq("mrst_done", get_done(4), 1'b0);
    check_eq("mrst_w", get_wnz(4), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("no_resume", get_busy(4), 1'b0);
    run_one(4, ka);

    // start accepted in the same cycle as done.
    kb = rnd_key();
    kc = rnd_key();
    start_dut(6, kb);
    wait_done(6, n);
    check_sched("b2b_first", 6, kb);
    start_dut(6, kc);
    check_eq("b2b_busy", get_busy(6), 1'b1);
    wait_done(6, n);
    check_eq("b2b_lat", 64'(n + 1), 64'd47);
    check_sched("b2b_second", 6, kc);

    // Stale words on a fresh start: zeroized or retained depending on build.
    ka = rnd_key();
    run_one(4, ka);
    prev = ref_sched(4, ka);
    kc = rnd_key();
    start_dut(4, kc);
`ifdef KEYEXP_ZEROIZE_EN
    check_eq("zero_w43", get_word(4, 43), 32'h0);
`else
    check_eq("keep_w43", get_word(4, 43), prev[1919-32*43 -: 32]);
`endif
    wait_done(4, n);
    check_sched("after_restart", 4, kc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have parameter Nk, default 4: number of 32-bit key words; legal values are 4, 6 and 8.
REQ-002 SHALL have parameter Nr, default 10: number of rounds; legal values are Nk+6 only.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request to expand key_in; sampled only while idle.
REQ-006 SHALL have port key_in, input, Nk*32 bits: cipher key; key word 0 occupies bits [Nk*32-1 -: 32].
REQ-007 SHALL have port busy, output, 1 bit: high while expansion is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse when w is complete.
REQ-009 SHALL have port w, output, (Nr+1)*128 bits: expanded key schedule; word j occupies bits [(Nr+1)*128-1-32*j -: 32], so round key r is [(Nr+1)*128-1-128*r -: 128].

Function
REQ-010 SHALL implement a two-state FSM: IDLE and EXPAND.
REQ-011 SHALL, in IDLE with start=1 at an edge, load key_in words into w[0..Nk-1], set the word index i to Nk, and enter EXPAND.
REQ-012 SHALL, at each EXPAND edge, write exactly one word: w[i] = w[i-Nk] ^ temp, where temp starts as w[i-1]; then i increments by 1.
REQ-013 SHALL, when i mod Nk == 0, set temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
REQ-014 SHALL, when Nk == 8 and i mod Nk == 4, set temp = SubWord(w[i-1]).
REQ-015 SHALL define RotWord{b0,b1,b2,b3} = {b1,b2,b3,b0}, with b0 as the most significant byte.
REQ-016 SHALL define SubWord as the AES forward S-box applied to each of the 4 bytes.
REQ-017 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-018 SHALL, at the edge that writes the last word 4*(Nr+1)-1, return to IDLE and register done=1 for exactly the following cycle.
REQ-019 SHALL hold busy = (state == EXPAND).
REQ-020 SHALL take 4*(Nr+1)-Nk EXPAND cycles: 40 for Nk=4, 46 for Nk=6, 52 for Nk=8.
REQ-021 SHALL ignore start while busy; the current expansion continues unaffected.
REQ-022 SHALL accept start=1 in the same cycle that done=1 and begin a new expansion.
REQ-023 SHALL hold w stable in IDLE; key_in changes during EXPAND have no effect.

Reset
REQ-024 SHALL, on rst=1 (asynchronous, including mid-expansion): state=IDLE, i=0, busy=0, done=0, all bits of w=0.
REQ-025 SHALL, after rst is released, ignore any partial expansion and require a new start.

Configuration
REQ-026 SHALL support macro KEYEXP_ZEROIZE_EN.
- Defined: the start-accept edge clears words Nk..4*(Nr+1)-1 of w to 0 while loading the key words.
- Undefined: those words retain their previous values until overwritten during EXPAND.
- Both settings: the final w after done is identical.

Structure
REQ-027 SHALL take the Rcon table, state encoding, and word-count constant/function 4*(Nr+1) from shared package aes_pkg.
REQ-028 SHALL instantiate combinational sub-module aes_sbox (8-bit in, 8-bit out) four times for SubWord; aes_sbox is reusable by the cipher stage.

Verification
REQ-029 SHALL check Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c -> w[4]=a0fafe17, w[43]=b6630ca6, done exactly 41 cycles after the start edge.
REQ-030 SHALL check Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
REQ-031 SHALL check Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[59]=706c631e.
REQ-032 SHALL check start re-pulsed with a different key at EXPAND cycle 10 -> ignored; final w matches the first key.
REQ-033 SHALL check rst asserted at EXPAND cycle 20 -> w=0, busy=0, done=0 immediately; a new start then gives the correct schedule.
REQ-034 SHALL check, with KEYEXP_ZEROIZE_EN defined, a second start after a prior expansion -> w[43]=0 on the cycle after the start edge.
